mux_16_1_rr_arbiter: RTL
========================

// Module: mux_16_1_rr_arbiter
// PURPOSE
// - Round-robin arbiter that shares one MUX_16_1 output between 16 requesters.
// - Grants one channel at a time, drives the MUX select/enable and holds the grant until the owner releases.
// - Inserts a one-cycle enable-low gap between owners so the tri-stated MUX output never glitches between sources.
// - Sits directly in front of MUX_16_1: Select_Out -> Select_In, MUX_Enable_Out -> Enable_In.
// PARAMETERS
// - MAX_HOLD_CYCLES  64  grant-hold limit in cycles; used only with MUX_ARB_TIMEOUT_EN; legal range 1..2^HOLD_CNT_W-1
// - HOLD_CNT_W       8   width of the hold-cycle counter
// PORTS
// - Clock_In          in   1   single clock; all state changes on the rising edge
// - Reset_In          in   1   asynchronous, active-high reset
// - Request_In        in   16  per-channel request; bit i = requester on Data_i_In
// - Channel_Mask_In   in   16  1 = channel may be granted; 0 = request ignored
// - Done_In           in   1   owner release pulse; ignored outside GRANT
// - Grant_Out         out  16  one-hot grant, or all zero
// - Select_Out        out  4   binary index of the current or most recent owner
// - MUX_Enable_Out    out  1   high only in GRANT
// - Busy_Out          out  1   high in GRANT or HANDOFF
// - Timeout_Out       out  1   one-cycle pulse on forced release
// BEHAVIOUR
// - Reset (async): Grant_Out=0, Select_Out=0, MUX_Enable_Out=0, Busy_Out=0, Timeout_Out=0, state=IDLE, Last_Grant=15, hold counter=0.
// - Reset mid-GRANT: outputs clear immediately, without waiting for a clock edge.
// - Eligible set: E = Request_In & Channel_Mask_In.
// - Search order: Last_Grant+1, Last_Grant+2, ... modulo 16 (15 wraps to 0). The first set bit of E wins.
// - All outputs are registered.
// - States:
//   - IDLE: if E != 0 at an edge -> GRANT. At that edge: Grant_Out = onehot(w), Select_Out = w, MUX_Enable_Out = 1, Busy_Out = 1, Last_Grant = w. Latency is 1 edge from request to grant.
//   - GRANT: release when any of these holds at an edge:
//     - Done_In = 1
//     - Request_In[owner] = 0
//     - Channel_Mask_In[owner] = 0
//     - timeout (macro only)
//     On release -> HANDOFF, with Grant_Out = 0 and MUX_Enable_Out = 0. Select_Out and Busy_Out hold.
//   - HANDOFF: exactly 1 cycle. Then:
//     - E != 0 -> GRANT to the next winner (search from Last_Grant+1).
//     - E == 0 -> IDLE with Busy_Out = 0.
// - The previous owner is granted again only if no other channel is eligible.
// - Requests arriving during GRANT or HANDOFF are only evaluated at the HANDOFF edge.
// - New requests never preempt the owner.
// - Simultaneous Done_In and a drop of Request_In[owner]: a single release.
// - Select_Out changes only when entering GRANT, so it is stable while MUX_Enable_Out = 1.
// - Invariants: popcount(Grant_Out) <= 1; MUX_Enable_Out == |Grant_Out.
// CONFIGURATION
// - Macro MUX_ARB_TIMEOUT_EN.
// - Defined:
//   - Hold counter clears on entering GRANT and increments each GRANT cycle.
//   - When the count reaches MAX_HOLD_CYCLES-1 with no other release cause, that edge forces the release.
//   - The grant therefore lasts exactly MAX_HOLD_CYCLES cycles.
//   - Timeout_Out pulses for the HANDOFF cycle.
//   - If a normal release coincides with the timeout edge, Timeout_Out stays 0.
// - Not defined: no counter is implemented, Timeout_Out is tied to 0, and a grant holds indefinitely.
// TESTING
// - Reset then Request_In=16'h0001 -> next edge: Grant_Out=16'h0001, Select_Out=0, MUX_Enable_Out=1.
// - Request_In=16'hFFFF held, owner pulses Done_In each grant -> owners 0,1,...,15,0 in order, each grant preceded by a 1-cycle MUX_Enable_Out=0 gap.
// - Last_Grant=15, Request_In=16'h8001, release -> next owner 0, Select_Out=0 (wrap-around).
// - Channel_Mask_In=16'hFFFE, Request_In=16'h0003 -> channel 0 never granted; clearing mask bit 5 while channel 5 owns -> release and HANDOFF.
// - MUX_ARB_TIMEOUT_EN, MAX_HOLD_CYCLES=4, Request_In=16'h0004 held -> grant high 4 cycles, then Timeout_Out=1 for 1 cycle, then re-grant of channel 2.
// - Reset_In asserted between clock edges mid-GRANT -> Grant_Out=0 and MUX_Enable_Out=0 with no clock edge; after release, Request_In=16'h0001 -> grant of channel 0.

Source files
------------

// File: rtl/mux_16_1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_16_1_rr_arbiter
// Description : Round-robin arbiter sharing one MUX_16_1 output between 16
//               requesters. Grants one channel at a time, drives the MUX
//               select/enable, holds the grant until the owner releases, and
//               inserts a one-cycle enable-low HANDOFF gap between owners so
//               the tri-stated MUX output never glitches between sources.
//               Connect Select_Out -> Select_In, MUX_Enable_Out -> Enable_In.
// Ports       : Clock_In        - single clock, rising edge
//               Reset_In        - asynchronous, active-high reset
//               Request_In      - per-channel request (bit i = Data_i_In)
//               Channel_Mask_In - 1 = channel may be granted
//               Done_In         - owner release pulse (ignored outside GRANT)
//               Grant_Out       - one-hot grant or all zero
//               Select_Out      - binary index of current/most recent owner
//               MUX_Enable_Out  - high only while a grant is active
//               Busy_Out        - high in GRANT or HANDOFF
//               Timeout_Out     - one-cycle pulse on forced release
// Options     : MUX_ARB_TIMEOUT_EN - when defined, a grant is force-released
//               after MAX_HOLD_CYCLES cycles; otherwise Timeout_Out is tied
//               low and a grant holds indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_16_1_rr_arbiter #(
    parameter int MAX_HOLD_CYCLES = 64,
    parameter int HOLD_CNT_W      = 8
) (
    input  logic        Clock_In,
    input  logic        Reset_In,
    input  logic [15:0] Request_In,
    input  logic [15:0] Channel_Mask_In,
    input  logic        Done_In,
    output logic [15:0] Grant_Out,
    output logic [3:0]  Select_Out,
    output logic        MUX_Enable_Out,
    output logic        Busy_Out,
    output logic        Timeout_Out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HANDOFF = 2'd2;

    // Reject a hold limit that the counter cannot represent.
    if (MAX_HOLD_CYCLES < 1 || MAX_HOLD_CYCLES > (2 ** HOLD_CNT_W) - 1) begin : g_bad_hold_param
        $error("mux_16_1_rr_arbiter: MAX_HOLD_CYCLES out of range for HOLD_CNT_W");
    end

    logic [1:0]  r_state;
    logic [3:0]  r_last_grant;
    logic [15:0] r_grant;
    logic [3:0]  r_select;
    logic        r_enable;
    logic        r_busy;

    logic [15:0] w_eligible;
    logic        w_found;
    logic [3:0]  w_winner;
    logic [3:0]  w_idx;
    logic        w_normal_release;
    logic        w_hold_expired;
    logic        w_release;
    logic        w_take;

    assign w_eligible = Request_In & Channel_Mask_In;

    // Search starts one past the last owner and wraps; the last owner itself
    // is examined last, so it only wins again when nobody else is eligible.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_idx    = '0;
        for (int i = 1; i <= 16; i++) begin
            w_idx = r_last_grant + 4'(i);
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Select_Out always names the current owner while in GRANT.
    assign w_normal_release = Done_In
                            | ~Request_In[r_select]
                            | ~Channel_Mask_In[r_select];
    assign w_release = (r_state == ST_GRANT) && (w_normal_release || w_hold_expired);
    assign w_take    = ((r_state == ST_IDLE) || (r_state == ST_HANDOFF)) && w_found;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] c_hold_last = HOLD_CNT_W'(MAX_HOLD_CYCLES - 1);

    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic                  r_timeout;

    assign w_hold_expired = (r_state == ST_GRANT) && (r_hold_cnt == c_hold_last);

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_hold_cnt <= '0;
        end else if (w_take) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_GRANT) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Pulse only when the limit alone caused the release; it lands on the
    // HANDOFF cycle and clears on the next edge since state leaves GRANT.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_hold_expired && !w_normal_release;
        end
    end

    assign Timeout_Out = r_timeout;
`else
    assign w_hold_expired = 1'b0;
    assign Timeout_Out    = 1'b0;
`endif

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 4'd15;
            r_grant      <= '0;
            r_select     <= '0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HANDOFF: begin
                    if (w_take) begin
                        r_state      <= ST_GRANT;
                        r_last_grant <= w_winner;
                        r_grant      <= 16'h0001 << w_winner;
                        r_select     <= w_winner;
                        r_enable     <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Select and Busy hold through the gap so the MUX select
                    // never moves while its enable is high.
                    if (w_release) begin
                        r_state  <= ST_HANDOFF;
                        r_grant  <= '0;
                        r_enable <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_grant  <= '0;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign Grant_Out      = r_grant;
    assign Select_Out     = r_select;
    assign MUX_Enable_Out = r_enable;
    assign Busy_Out       = r_busy;

endmodule
`default_nettype wire
